// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with row synchronizer and debounce
// Drives one column low at a time, samples rows once per dwell period, debounces press and release.
module keypad_scanner #(
   parameter int SCAN_DIV       = 131072,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);
   localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [3:0]    DEB_LAST   = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

   state_t        state, state_n;
   logic [3:0]    rows_m, rows_s;
   logic [DW-1:0] dwell;
   logic [1:0]    col_idx, col_n;
   logic [1:0]    cand_row, cand_n;
   logic [3:0]    deb_cnt, deb_n, deb_inc;
   logic [3:0]    code_n;
   logic          valid_n, held_n;
   logic          tick, press;
   logic [1:0]    row_idx;

   assign tick    = (dwell == DWELL_LAST);
   assign press   = (rows_s != 4'b1111);
   assign deb_inc = deb_cnt + 4'd1;
   assign col_out = ~(4'b0001 << col_idx);

   // Lowest-index active row wins when several keys share a column.
   always_comb begin
      row_idx = 2'd0;
      if (!rows_s[0])      row_idx = 2'd0;
      else if (!rows_s[1]) row_idx = 2'd1;
      else if (!rows_s[2]) row_idx = 2'd2;
      else if (!rows_s[3]) row_idx = 2'd3;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rows_m    <= 4'b1111;
         rows_s    <= 4'b1111;
         dwell     <= '0;
         state     <= SCAN;
         col_idx   <= 2'd0;
         cand_row  <= 2'd0;
         deb_cnt   <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         rows_m    <= row_in;
         rows_s    <= rows_m;
         dwell     <= tick ? '0 : dwell + 1'b1;
         state     <= state_n;
         col_idx   <= col_n;
         cand_row  <= cand_n;
         deb_cnt   <= deb_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_held  <= held_n;
      end
   end

   always_comb begin
      state_n = state;
      col_n   = col_idx;
      cand_n  = cand_row;
      deb_n   = deb_cnt;
      code_n  = key_code;
      valid_n = 1'b0;
      held_n  = key_held;
      if (tick) begin
         case (state)
            SCAN: begin
               if (press) begin
                  cand_n  = row_idx;
                  deb_n   = 4'd1;
                  state_n = DEBOUNCE;
               end else begin
                  col_n = col_idx + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (press && (row_idx == cand_row)) begin
                  deb_n = deb_inc;
                  if (deb_inc == DEB_LAST) begin
                     state_n = PRESSED;
                     code_n  = {cand_row, col_idx};
                     valid_n = 1'b1;
                     held_n  = 1'b1;
                  end
               end else begin
                  state_n = SCAN;
                  col_n   = col_idx + 2'd1;
               end
            end
            PRESSED: begin
               if (!press) begin
                  deb_n   = 4'd1;
                  state_n = RELEASE;
               end
            end
            RELEASE: begin
               if (!press) begin
                  deb_n = deb_inc;
                  if (deb_inc == DEB_LAST) begin
                     held_n  = 1'b0;
                     col_n   = col_idx + 2'd1;
                     state_n = SCAN;
                  end
               end else begin
                  // A press during release confirmation is contact bounce, not a new key.
                  state_n = PRESSED;
               end
            end
            default: state_n = SCAN;
         endcase
      end
   end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
// Keypad matrix model drives rows from col_out; a behavioural model is compared every cycle.
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DS = 3;
   localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] row_in;
   logic [3:0] col_out, key_code;
   logic       key_valid, key_held;
   logic [3:0] km [4];
   int         checks = 0, failures = 0;
   int         cyc = 0;
   bit         cmp_en = 1'b0;

   int         m_col = 0, m_t = 0, m_mode = M_SCAN, m_cand = 0, m_cnt = 0, m_code = 0;
   bit         m_valid = 0, m_held = 0;
   logic [3:0] m_s1 = 4'hf, m_s = 4'hf;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clk(clk), .reset_n(reset_n), .row_in(row_in), .col_out(col_out),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to the active-low column.
   always_comb begin
      for (int r = 0; r < 4; r++) row_in[r] = ~|(km[r] & ~col_out);
   end

   always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [3:0] rows_for(input int c);
      logic [3:0] v;
      for (int r = 0; r < 4; r++) v[r] = ~km[r][c];
      return v;
   endfunction

   function automatic int lowest(input logic [3:0] v);
      for (int r = 0; r < 4; r++) if (!v[r]) return r;
      return 0;
   endfunction

   // Behavioural model: rows seen two cycles late, decisions once per SD cycles.
   always @(posedge clk) begin : model
      logic [3:0] rows_now;
      bit         pr;
      int         r;
      if (!reset_n) begin
         m_col = 0; m_t = 0; m_mode = M_SCAN; m_cand = 0; m_cnt = 0;
         m_code = 0; m_valid = 0; m_held = 0; m_s1 = 4'hf; m_s = 4'hf;
      end else begin
         rows_now = rows_for(m_col);
         m_valid = 0;
         if (m_t == SD - 1) begin
            pr = (m_s != 4'hf);
            r  = lowest(m_s);
            case (m_mode)
               M_SCAN: if (pr) begin m_cand = r; m_cnt = 1; m_mode = M_DEB; end
                       else m_col = (m_col + 1) % 4;
               M_DEB: if (pr && r == m_cand) begin
                         m_cnt++;
                         if (m_cnt == DS) begin
                            m_mode = M_HELD; m_valid = 1; m_held = 1; m_code = m_cand * 4 + m_col;
                         end
                      end else begin m_mode = M_SCAN; m_col = (m_col + 1) % 4; end
               M_HELD: if (!pr) begin m_cnt = 1; m_mode = M_REL; end
               default: if (!pr) begin
                           m_cnt++;
                           if (m_cnt == DS) begin m_held = 0; m_col = (m_col + 1) % 4; m_mode = M_SCAN; end
                        end else m_mode = M_HELD;
            endcase
         end
         m_t = (m_t + 1) % SD;
         m_s = m_s1;
         m_s1 = rows_now;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("col_out", int'(col_out), int'(~(4'b0001 << m_col) & 4'hf));
         chk("key_code", int'(key_code), m_code);
         chk("key_valid", int'(key_valid), int'(m_valid));
         chk("key_held", int'(key_held), int'(m_held));
      end
   end

   task automatic clear_keys();
      for (int r = 0; r < 4; r++) km[r] = 4'h0;
   endtask

   task automatic wait_valid(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         if (key_valid) begin at = cyc; break; end
         @(negedge clk);
      end
      chk("valid_seen", int'(at >= 0), 1);
   endtask

   task automatic wait_held_low(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         if (!key_held) begin at = cyc; break; end
         @(negedge clk);
      end
      chk("held_fall_seen", int'(at >= 0), 1);
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [3:0] idle_cols [4];
      int at, nv, t, t1, c0, nlow;
      idle_cols[0] = 4'b1110; idle_cols[1] = 4'b1101; idle_cols[2] = 4'b1011; idle_cols[3] = 4'b0111;
      clear_keys();
      @(posedge clk);
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_col", int'(col_out), 4'he);
      chk("rst_code", int'(key_code), 0);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_held", int'(key_held), 0);

      // Idle scanning.
      reset_n = 1'b1;
      nv = 0;
      for (int k = 0; k < 64; k++) begin
         if (k % 4 == 0) chk("idle_col", int'(col_out), int'(idle_cols[(k / 4) % 4]));
         if (key_valid) nv++;
         @(negedge clk);
      end
      chk("idle_no_valid", nv, 0);

      // Key row1/col2 held from reset.
      reset_n = 1'b0;
      km[1][2] = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_valid(100, at);
      chk("first_valid_cycle", at, 20);
      chk("first_code", int'(key_code), 4'b0110);
      chk("first_held", int'(key_held), 1);
      @(negedge clk);
      chk("valid_one_cycle", int'(key_valid), 0);
      nv = 0;
      repeat (180) begin if (key_valid) nv++; @(negedge clk); end
      chk("no_autorepeat", nv, 0);
      km[1][2] = 1'b0;
      t = cyc;
      t1 = t + 2;
      while (t1 % 4 != 3) t1++;
      wait_held_low(100, at);
      chk("held_fall_cycle", at, t1 + 9);
      chk("resume_col3", int'(col_out), 4'b0111);

      // One-tick bounce at row0/col1.
      c0 = 0;
      for (int i = 0; i < 40 && !(col_out == 4'b1101 && cyc % 4 == 0); i++) begin @(negedge clk); c0++; end
      chk("bounce_align", int'(col_out), 4'b1101);
      km[0][1] = 1'b1;
      repeat (4) @(negedge clk);
      chk("bounce_col_held", int'(col_out), 4'b1101);
      km[0][1] = 1'b0;
      nv = 0;
      repeat (24) begin if (key_valid) nv++; @(negedge clk); end
      chk("bounce_no_valid", nv, 0);
      chk("bounce_code_kept", int'(key_code), 4'b0110);

      // Brief release while pressed.
      km[2][0] = 1'b1;
      wait_valid(100, at);
      chk("r2c0_code", int'(key_code), 4'b1000);
      repeat (10) @(negedge clk);
      km[2][0] = 1'b0;
      repeat (4) @(negedge clk);
      km[2][0] = 1'b1;
      nv = 0; nlow = 0;
      repeat (40) begin
         if (key_valid) nv++;
         if (!key_held) nlow++;
         @(negedge clk);
      end
      chk("rebounce_no_valid", nv, 0);
      chk("rebounce_held", nlow, 0);
      km[2][0] = 1'b0;
      wait_held_low(100, at);

      // Two keys in col0, then reset mid-debounce.
      km[1][0] = 1'b1; km[3][0] = 1'b1;
      wait_valid(100, at);
      chk("multi_code", int'(key_code), 4'b0100);
      clear_keys();
      wait_held_low(100, at);
      km[0][3] = 1'b1;
      for (int i = 0; i < 100 && m_mode != M_DEB; i++) @(negedge clk);
      chk("reached_debounce", m_mode, M_DEB);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_col", int'(col_out), 4'he);
      chk("abort_code", int'(key_code), 0);
      chk("abort_valid", int'(key_valid), 0);
      chk("abort_held", int'(key_held), 0);
      reset_n = 1'b1;
      clear_keys();

      // Random key activity with occasional resets.
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 3))
            0: clear_keys();
            1: begin clear_keys(); km[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1; end
            2: km[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            default: ;
         endcase
         if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 2));
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
